pixel_scan_sequencer: RTL and testbench
=======================================

PIXEL_SCAN_SEQUENCER -- requirements
Module: pixel_scan_sequencer

Interface
REQ-001 Parameter CNT_W, 32, width of each pixel counter value and of sample_out.
REQ-002 Parameter NUM_CH, 5, number of counter channels read per pixel address.
REQ-003 Parameter NUM_PX, 4, pixel addresses per channel; px_addr width is 2.
REQ-004 Parameter SETTLE_CYCLES, 4, oscillator settle time before counting (must be >=1).
REQ-005 Parameter WIN_CYCLES, 1000, count-window length in clk cycles (must be >=1).
REQ-006 One clock; reset is synchronous and active-high: port clk, input, 1, system clock; port rst, input, 1, synchronous active-high reset.
REQ-007 start  input  1  one-cycle request to begin a scan frame.
REQ-008 continuous  input  1  when 1, a completed frame restarts automatically.
REQ-009 abort  input  1  synchronous abort of any frame in progress.
REQ-010 osc_mask  input  NUM_CH  a bit set to 1 forces that channel's stop_osc high at all times.
REQ-011 counter_val  input  NUM_CH*CNT_W  flattened counter outputs; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-012 ack_received  input  1  level from the I2C slave; a rising edge consumes the current word.
REQ-013 px_addr  output  2  pixel select driven to the oscillator muxes.
REQ-014 stop_osc  output  NUM_CH  per-channel oscillator off (1 = off).
REQ-015 en_osc_out  output  1  mux enable, which gates the counter clocks.
REQ-016 clr_counter  output  1  counter clear.
REQ-017 sample_out  output  CNT_W  word presented to the I2C registers.
REQ-018 drdy  output  1  sample_out is valid.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 frame_done  output  1  one-cycle pulse at the end of a frame.

Function
REQ-021 The FSM SHALL have the states IDLE, CLEAR, SETTLE, COUNT, HOLD, XFER, NEXT.
REQ-022 IDLE: stop_osc all 1, en_osc_out 0, drdy 0; a start pulse moves the FSM to CLEAR with px_addr=0.
REQ-023 CLEAR: clr_counter=1 for exactly 1 cycle; then SETTLE.
REQ-024 In SETTLE, COUNT and HOLD, stop_osc SHALL equal osc_mask; in all other states stop_osc is all 1.
REQ-025 SETTLE SHALL last SETTLE_CYCLES cycles with en_osc_out 0; then COUNT.
REQ-026 COUNT SHALL hold en_osc_out=1 for exactly WIN_CYCLES cycles; then HOLD.
REQ-027 HOLD SHALL last 2 cycles with en_osc_out 0, letting the asynchronous counters settle; then XFER with channel index ch=0.
REQ-028 XFER: in the first cycle, sample_out is registered from counter_val channel ch and drdy is asserted; both are held stable until an ack_received rising edge is detected.
REQ-029 On an ack rising edge while drdy=1, drdy SHALL deassert on the next cycle; ch increments, or the FSM moves to NEXT after ch=NUM_CH-1.
REQ-030 Edges of ack_received while drdy=0 SHALL be ignored; an ack held high SHALL consume exactly one word.
REQ-031 NEXT (1 cycle): if px_addr<NUM_PX-1, px_addr increments and the FSM goes to CLEAR; otherwise frame_done pulses, px_addr wraps to 0, and the FSM goes to CLEAR if continuous=1, else IDLE.
REQ-032 start while busy=1 SHALL be ignored.
REQ-033 abort SHALL force IDLE on the next cycle from any state: drdy 0, px_addr 0, no frame_done; abort has priority over start and ack in the same cycle.
REQ-034 px_addr SHALL change only in NEXT, IDLE-entry or reset, never while en_osc_out=1.

Reset
REQ-035 On rst=1 at a clk edge: state IDLE, px_addr 0, stop_osc all 1, en_osc_out 0, clr_counter 1, sample_out 0, drdy 0, busy 0, frame_done 0, ch 0, timers 0, ack edge-detector register 0.
REQ-036 clr_counter SHALL drop to 0 on the first cycle after rst deasserts; reset mid-frame behaves as REQ-035.

Structure
REQ-037 Package pixel_scan_pkg SHALL hold the state enumeration and the default values of CNT_W, NUM_CH, NUM_PX, SETTLE_CYCLES and WIN_CYCLES.
REQ-038 One sub-module, scan_window_timer, SHALL provide a loadable down-counter with a done flag, width $clog2(max(SETTLE_CYCLES, WIN_CYCLES)+1); it is shared by SETTLE and COUNT.

Verification (SETTLE_CYCLES=2, WIN_CYCLES=8)
REQ-039 start with continuous=0 and ack pulsed 3 cycles after each drdy -> exactly 20 words in order px0 ch0..4 through px3 ch0..4, frame_done once, return to IDLE.
REQ-040 Count en_osc_out=1 cycles per pixel -> exactly 8; clr_counter pulse width 1; px_addr stable throughout COUNT.
REQ-041 counter_val ch2=0xDEADBEEF, and counter_val changed while drdy=1 -> sample_out=0xDEADBEEF and held unchanged until ack.
REQ-042 ack_received held high for 10 cycles -> exactly one word consumed; ack pulse while drdy=0 -> no effect.
REQ-043 abort during COUNT of px2, and abort plus start in the same cycle -> IDLE next cycle, px_addr=0, drdy 0, start ignored.
REQ-044 continuous=1 -> frame_done followed by CLEAR with px_addr=0; osc_mask=5'b00100 -> stop_osc[2] stays 1 throughout.

Source files
------------

// File: rtl/pixel_scan_pkg.sv
// Shared types and default parameters for the pixel scan sequencer.
package pixel_scan_pkg;

    localparam int CNT_W_DEF         = 32;
    localparam int NUM_CH_DEF        = 5;
    localparam int NUM_PX_DEF        = 4;
    localparam int SETTLE_CYCLES_DEF = 4;
    localparam int WIN_CYCLES_DEF    = 1000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_COUNT,
        S_HOLD,
        S_XFER,
        S_NEXT
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_window_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module scan_window_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/pixel_scan_sequencer.sv
// Steps through pixel addresses, times the oscillator count window and hands
// each channel's count to the I2C side one word per ack.
module pixel_scan_sequencer
    import pixel_scan_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int NUM_CH        = NUM_CH_DEF,
    parameter int NUM_PX        = NUM_PX_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int WIN_CYCLES    = WIN_CYCLES_DEF,
    localparam int PX_W         = (NUM_PX > 1) ? $clog2(NUM_PX) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    continuous,
    input  logic                    abort,
    input  logic [NUM_CH-1:0]       osc_mask,
    input  logic [NUM_CH*CNT_W-1:0] counter_val,
    input  logic                    ack_received,
    output logic [PX_W-1:0]         px_addr,
    output logic [NUM_CH-1:0]       stop_osc,
    output logic                    en_osc_out,
    output logic                    clr_counter,
    output logic [CNT_W-1:0]        sample_out,
    output logic                    drdy,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int TMR_W = $clog2(max_int(SETTLE_CYCLES, WIN_CYCLES) + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t           state, next_state;
    logic [CH_W-1:0]  ch;
    logic             ack_q;
    logic             in_reset;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;
    logic             ack_rise;
    logic             last_ch;
    logic             last_px;

    assign ack_rise = ack_received & ~ack_q;
    assign last_ch  = (ch == CH_W'(NUM_CH - 1));
    assign last_px  = (px_addr == PX_W'(NUM_PX - 1));

    // One timer serves SETTLE, COUNT and the two-cycle HOLD.
    scan_window_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        if (abort) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) next_state = S_CLEAR;
                S_CLEAR: begin
                    next_state = S_SETTLE;
                    tmr_load   = 1'b1;
                    tmr_val    = TMR_W'(SETTLE_CYCLES - 1);
                end
                S_SETTLE: if (tmr_done) begin
                    next_state = S_COUNT;
                    tmr_load   = 1'b1;
                    tmr_val    = TMR_W'(WIN_CYCLES - 1);
                end
                S_COUNT: if (tmr_done) begin
                    next_state = S_HOLD;
                    tmr_load   = 1'b1;
                    tmr_val    = TMR_W'(1);
                end
                S_HOLD: if (tmr_done) next_state = S_XFER;
                S_XFER: if (drdy && ack_rise && last_ch) next_state = S_NEXT;
                S_NEXT: next_state = (!last_px || continuous) ? S_CLEAR : S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        stop_osc    = '1;
        en_osc_out  = 1'b0;
        clr_counter = in_reset;
        busy        = (state != S_IDLE);
        case (state)
            S_CLEAR:          clr_counter = 1'b1;
            S_SETTLE, S_HOLD: stop_osc    = osc_mask;
            S_COUNT: begin
                stop_osc   = osc_mask;
                en_osc_out = 1'b1;
            end
            default: ;
        endcase
    end

    // Word handshake, pixel stepping and the frame_done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            px_addr    <= '0;
            ch         <= '0;
            sample_out <= '0;
            drdy       <= 1'b0;
            frame_done <= 1'b0;
            ack_q      <= 1'b0;
            in_reset   <= 1'b1;
        end else begin
            in_reset   <= 1'b0;
            ack_q      <= ack_received;
            frame_done <= 1'b0;
            if (abort) begin
                px_addr <= '0;
                ch      <= '0;
                drdy    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (start) px_addr <= '0;
                    S_XFER: begin
                        if (!drdy) begin
                            sample_out <= counter_val[int'(ch)*CNT_W +: CNT_W];
                            drdy       <= 1'b1;
                        end else if (ack_rise) begin
                            drdy <= 1'b0;
                            ch   <= last_ch ? '0 : ch + CH_W'(1);
                        end
                    end
                    S_NEXT: begin
                        if (last_px) begin
                            px_addr    <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            px_addr <= px_addr + PX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// Self-checking bench: a timeline model of the scan frame is compared with
// the DUT every cycle, plus literal expectations for the directed scenarios.
module tb_pixel_scan_sequencer;

    localparam int CNT_W  = 32;
    localparam int NUM_CH = 5;
    localparam int NUM_PX = 4;
    localparam int SETTLE = 2;
    localparam int WIN    = 8;
    localparam int L      = SETTLE + WIN + 3;  // cycles before the first word of a pixel

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, continuous = 1'b0, abort = 1'b0;
    logic auto_ack = 1'b0, ack_auto = 1'b0, ack_man = 1'b0;
    logic ack_received;
    logic [NUM_CH-1:0]       osc_mask = '0;
    logic [NUM_CH*CNT_W-1:0] counter_val = '0;
    logic [1:0]              px_addr;
    logic [NUM_CH-1:0]       stop_osc;
    logic                    en_osc_out, clr_counter, drdy, busy, frame_done;
    logic [CNT_W-1:0]        sample_out;

    assign ack_received = auto_ack ? ack_auto : ack_man;

    always #5 clk = ~clk;

    pixel_scan_sequencer #(
        .CNT_W(CNT_W), .NUM_CH(NUM_CH), .NUM_PX(NUM_PX),
        .SETTLE_CYCLES(SETTLE), .WIN_CYCLES(WIN)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
        .osc_mask(osc_mask), .counter_val(counter_val), .ack_received(ack_received),
        .px_addr(px_addr), .stop_osc(stop_osc), .en_osc_out(en_osc_out),
        .clr_counter(clr_counter), .sample_out(sample_out), .drdy(drdy),
        .busy(busy), .frame_done(frame_done)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] pattern(input int p, input int i);
        if (p == 0 && i == 2) return 32'hDEADBEEF;
        return 32'h5A00_0000 | 32'(p << 8) | 32'(i);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Counter values follow a known pattern, scrambled while a word is on offer.
    int ack_wait = 0;
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < NUM_CH; i++)
            counter_val[i*CNT_W +: CNT_W] = drdy ? $urandom : pattern(int'(px_addr), i);
        if (drdy) begin
            ack_wait++;
            ack_auto = (ack_wait == 3);
        end else begin
            ack_wait = 0;
            ack_auto = 1'b0;
        end
    end

    // Timeline model: offset 0 clear, then settle, count, hold; offset L is the
    // word handshake, L+1 the pixel step.
    bit m_valid = 0, m_busy = 0, m_drdy = 0, m_ackq = 0, m_fd = 0, m_inrst = 0;
    int m_px = 0, m_off = 0, m_ch = 0;
    logic [CNT_W-1:0] m_sample = '0;

    always @(posedge clk) begin
        bit rise;
        rise = ack_received && !m_ackq;
        if (rst) begin
            m_valid = 1; m_busy = 0; m_drdy = 0; m_ackq = 0; m_fd = 0; m_inrst = 1;
            m_px = 0; m_off = 0; m_ch = 0; m_sample = '0;
        end else begin
            m_inrst = 0;
            m_fd    = 0;
            m_ackq  = ack_received;
            if (abort) begin
                m_busy = 0; m_px = 0; m_ch = 0; m_drdy = 0;
            end else if (!m_busy) begin
                if (start) begin m_busy = 1; m_off = 0; m_px = 0; end
            end else if (m_off < L) begin
                m_off++;
            end else if (m_off == L) begin
                if (!m_drdy) begin
                    m_sample = counter_val[m_ch*CNT_W +: CNT_W];
                    m_drdy   = 1;
                end else if (rise) begin
                    m_drdy = 0;
                    if (m_ch == NUM_CH - 1) begin m_ch = 0; m_off = L + 1; end
                    else m_ch++;
                end
            end else begin
                if (m_px == NUM_PX - 1) begin
                    m_fd = 1; m_px = 0;
                    if (continuous) m_off = 0; else m_busy = 0;
                end else begin
                    m_px++; m_off = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [NUM_CH-1:0] exp_stop;
        if (m_valid) begin
            exp_stop = (m_busy && m_off >= 1 && m_off <= L - 1) ? osc_mask : '1;
            check("busy",        busy,        m_busy);
            check("clr_counter", clr_counter, m_inrst || (m_busy && m_off == 0));
            check("en_osc_out",  en_osc_out,  m_busy && m_off >= SETTLE + 1 && m_off <= SETTLE + WIN);
            check("stop_osc",    stop_osc,    exp_stop);
            check("px_addr",     px_addr,     m_px);
            check("drdy",        drdy,        m_drdy);
            check("sample_out",  sample_out,  m_sample);
            check("frame_done",  frame_done,  m_fd);
        end
    end

    // Observers for the directed scenarios.
    logic [31:0] words[$];
    int en_runs[$], clr_widths[$];
    int fd_count = 0, drdy_falls = 0, px_moved = 0, stop2_low = 0, en_run = 0, clr_run = 0;
    bit prev_drdy = 0, prev_en = 0;
    logic [1:0] prev_px = '0;
    always @(negedge clk) begin
        if (drdy && !prev_drdy) words.push_back(sample_out);
        if (!drdy && prev_drdy) drdy_falls++;
        if (frame_done === 1'b1) fd_count++;
        if (en_osc_out) begin
            en_run++;
            if (prev_en && px_addr != prev_px) px_moved++;
        end else if (prev_en) begin
            en_runs.push_back(en_run);
            en_run = 0;
        end
        if (clr_counter) clr_run++;
        else if (clr_run != 0) begin clr_widths.push_back(clr_run); clr_run = 0; end
        if (stop_osc[2] === 1'b0) stop2_low++;
        prev_drdy = drdy; prev_en = en_osc_out; prev_px = px_addr;
    end

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin tick(); n++; end
        check(name, busy, 1'b0);
    endtask

    task automatic wait_drdy(input string name, input int budget);
        int n = 0;
        while (drdy !== 1'b1 && n < budget) begin tick(); n++; end
        check(name, drdy, 1'b1);
    endtask

    initial begin
        int w0, f0, e0, c0, s0, d0, n;

        // Reset values
        tick(3);
        check("rst_clr", clr_counter, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_stop", stop_osc, 5'h1F);
        check("rst_drdy", drdy, 1'b0);
        check("rst_px", px_addr, 2'd0);
        check("rst_sample", sample_out, 32'h0);
        rst = 1'b0;
        tick();
        check("clr_after_rst", clr_counter, 1'b0);
        tick(2);

        // Full single frame with auto ack
        w0 = words.size(); f0 = fd_count; e0 = en_runs.size(); c0 = clr_widths.size();
        auto_ack = 1'b1;
        pulse_start();
        wait_idle("frame1_idle", 2000);
        tick(2);
        check("frame1_words", words.size() - w0, 20);
        for (int k = 0; k < 20 && w0 + k < words.size(); k++)
            check($sformatf("word_px%0d_ch%0d", k / NUM_CH, k % NUM_CH), words[w0 + k], pattern(k / NUM_CH, k % NUM_CH));
        if (words.size() > w0 + 2) check("word_deadbeef", words[w0 + 2], 32'hDEADBEEF);
        check("frame1_done_count", fd_count - f0, 1);
        check("frame1_en_runs", en_runs.size() - e0, NUM_PX);
        for (int k = e0; k < en_runs.size(); k++) check("en_run_len", en_runs[k], WIN);
        check("frame1_clr_pulses", clr_widths.size() - c0, NUM_PX);
        for (int k = c0; k < clr_widths.size(); k++) check("clr_width", clr_widths[k], 1);

        // Stray ack while drdy low, then ack held high for 10 cycles
        auto_ack = 1'b0;
        pulse_start();
        n = 0;
        while (en_osc_out !== 1'b1 && n < 50) begin tick(); n++; end
        check("reach_count", en_osc_out, 1'b1);
        ack_man = 1'b1; tick(); ack_man = 1'b0;
        wait_drdy("first_drdy", 100);
        d0 = drdy_falls;
        tick(5);
        check("stray_ack_ignored", drdy, 1'b1);
        ack_man = 1'b1;
        tick(10);
        check("held_ack_one_word", drdy_falls - d0, 1);
        check("held_ack_reloaded", drdy, 1'b1);
        ack_man = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_xfer_busy", busy, 1'b0);

        // Abort in COUNT of px2
        auto_ack = 1'b1;
        f0 = fd_count;
        pulse_start();
        n = 0;
        while (!(px_addr == 2'd2 && en_osc_out === 1'b1) && n < 2000) begin tick(); n++; end
        check("reach_px2_count", {px_addr, en_osc_out}, {2'd2, 1'b1});
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_px2_busy", busy, 1'b0);
        check("abort_px2_px", px_addr, 2'd0);
        check("abort_px2_drdy", drdy, 1'b0);
        tick();
        check("abort_px2_no_fd", fd_count - f0, 0);

        // Abort together with start and an ack edge
        auto_ack = 1'b0;
        pulse_start();
        wait_drdy("abort2_drdy", 100);
        abort = 1'b1; start = 1'b1; ack_man = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0; ack_man = 1'b0;
        check("abort_start_busy", busy, 1'b0);
        check("abort_start_px", px_addr, 2'd0);
        check("abort_start_drdy", drdy, 1'b0);
        tick();
        check("abort_start_stays_idle", busy, 1'b0);

        // Continuous mode with channel 2 masked
        auto_ack = 1'b1; continuous = 1'b1; osc_mask = 5'b00100;
        f0 = fd_count; s0 = stop2_low;
        pulse_start();
        n = 0;
        while (frame_done !== 1'b1 && n < 2000) begin tick(); n++; end
        check("cont_fd_seen", frame_done, 1'b1);
        check("cont_clear_after_fd", clr_counter, 1'b1);
        check("cont_px_wrap", px_addr, 2'd0);
        check("cont_still_busy", busy, 1'b1);
        continuous = 1'b0;
        tick();
        wait_idle("cont_second_frame_idle", 2000);
        tick(2);
        check("cont_fd_count", fd_count - f0, 2);
        check("mask2_stop_high", stop2_low - s0, 0);
        osc_mask = '0;

        // Reset in the middle of a frame
        pulse_start();
        tick(7);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_clr", clr_counter, 1'b1);
        tick();
        check("midrst_clr_drop", clr_counter, 1'b0);

        // Randomized traffic against the model
        auto_ack = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            start   = ($urandom_range(0, 15) == 0);
            abort   = ($urandom_range(0, 299) == 0);
            rst     = ($urandom_range(0, 999) == 0);
            ack_man = ($urandom_range(0, 2) == 0);
            if (c % 250 == 0) begin
                continuous = 1'($urandom_range(0, 1));
                osc_mask   = 5'($urandom);
            end
            tick();
        end
        start = 1'b0; rst = 1'b0; ack_man = 1'b0; continuous = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        tick(2);
        check("final_idle", busy, 1'b0);
        check("px_stable_in_count", px_moved, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
